// File: rtl/unidad_control_multiciclo_if.sv
// Control bundle between the multicycle control unit and the MIPS-subset datapath.
// Carries the IR opcode, the memory handshake, every datapath select/enable and the retire status.
// The control unit drives the master modport; the datapath (or a bench) uses the slave modport.
interface unidad_control_multiciclo_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       op;
   logic             mem_ready;
   logic             PCWrite;
   logic             PCWriteCond;
   logic             IorD;
   logic             MemRead;
   logic             MemToWrite;
   logic             IRWrite;
   logic             MemToReg;
   logic             RegDst;
   logic             RegWrite;
   logic             ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [2:0]       ALUOp;
   logic [1:0]       PCSource;
   logic             instr_done;
   logic [CNT_W-1:0] instr_count;
   logic             trap;

   modport master (
      input  op, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite,
             MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             instr_done, instr_count, trap
   );

   modport slave (
      output op, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite,
             MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             instr_done, instr_count, trap
   );
endinterface

// File: rtl/unidad_control_multiciclo.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB for R, LW, SW, BEQ, ADDI, J; counts retirements.
// Latency at mem_ready=1: BEQ/J 3, R/SW/ADDI 4, LW 5 cycles; undefined op is a 2-cycle NOP unless ILLEGAL_TRAP_EN.
// Backpressure: mem_ready=0 holds FETCH, MEMRD and MEMWR (strobes stay asserted), adding one cycle per low cycle.
module unidad_control_multiciclo #(
   parameter int CNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   unidad_control_multiciclo_if.master   bus
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_RTWB,
      S_BRANCH,
      S_ADDIEX,
      S_ADDIWB,
      S_JUMP,
      S_TRAP
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   ctrl_t            ctrl_d;
   ctrl_t            ctrl_o;

   // Output decode and next-state selection from the current state (mem_ready qualifies the memory states)
   always_comb begin
      ctrl_d  = '0;
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            ctrl_d.mem_read  = 1'b1;
            ctrl_d.alu_src_b = 2'b01;
            ctrl_d.ir_write  = bus.mem_ready;
            ctrl_d.pc_write  = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // ALU precomputes the branch target while the opcode is examined
            ctrl_d.alu_src_b = 2'b11;
            case (bus.op)
               OP_R:          state_d = S_EXEC;
               OP_LW, OP_SW:  state_d = S_MEMADR;
               OP_BEQ:        state_d = S_BRANCH;
               OP_ADDI:       state_d = S_ADDIEX;
               OP_J:          state_d = S_JUMP;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_d = S_TRAP;
`else
                  ctrl_d.instr_done = 1'b1;
                  state_d           = S_FETCH;
`endif
               end
            endcase
         end
         S_MEMADR: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
            state_d          = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            ctrl_d.iord     = 1'b1;
            ctrl_d.mem_read = 1'b1;
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.instr_done = 1'b1;
            state_d           = S_FETCH;
         end
         S_MEMWR: begin
            ctrl_d.iord       = 1'b1;
            ctrl_d.mem_write  = 1'b1;
            ctrl_d.instr_done = bus.mem_ready;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_op    = 3'b010;
            state_d          = S_RTWB;
         end
         S_RTWB: begin
            ctrl_d.reg_dst    = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.instr_done = 1'b1;
            state_d           = S_FETCH;
         end
         S_BRANCH: begin
            ctrl_d.alu_src_a     = 1'b1;
            ctrl_d.alu_op        = 3'b001;
            ctrl_d.pc_write_cond = 1'b1;
            ctrl_d.pc_source     = 2'b01;
            ctrl_d.instr_done    = 1'b1;
            state_d              = S_FETCH;
         end
         S_ADDIEX: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
            state_d          = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.instr_done = 1'b1;
            state_d           = S_FETCH;
         end
         S_JUMP: begin
            ctrl_d.pc_write   = 1'b1;
            ctrl_d.pc_source  = 2'b10;
            ctrl_d.instr_done = 1'b1;
            state_d           = S_FETCH;
         end
         // Only reachable with the trap build: sink with every strobe low, left only by reset
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   // State register and retired-instruction counter; reset abandons any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (ctrl_d.instr_done) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Reset masks the decode so nothing strobes while rst_n is low (FETCH would otherwise read memory)
   always_comb begin
      ctrl_o = rst_n ? ctrl_d : '0;
   end

   assign bus.PCWrite     = ctrl_o.pc_write;
   assign bus.PCWriteCond = ctrl_o.pc_write_cond;
   assign bus.IorD        = ctrl_o.iord;
   assign bus.MemRead     = ctrl_o.mem_read;
   assign bus.MemToWrite  = ctrl_o.mem_write;
   assign bus.IRWrite     = ctrl_o.ir_write;
   assign bus.MemToReg    = ctrl_o.mem_to_reg;
   assign bus.RegDst      = ctrl_o.reg_dst;
   assign bus.RegWrite    = ctrl_o.reg_write;
   assign bus.ALUSrcA     = ctrl_o.alu_src_a;
   assign bus.ALUSrcB     = ctrl_o.alu_src_b;
   assign bus.ALUOp       = ctrl_o.alu_op;
   assign bus.PCSource    = ctrl_o.pc_source;
   assign bus.instr_done  = ctrl_o.instr_done;
   assign bus.instr_count = cnt_q;

`ifdef ILLEGAL_TRAP_EN
   assign bus.trap = rst_n && (state_q == S_TRAP);
`else
   assign bus.trap = 1'b0;
`endif

endmodule
